sd_host_arbiter: RTL

Shares the single host-side SD block channel (sd_lba/sd_rd/sd_wr/sd_ack plus the sd_buff byte bus) between NUM_DEV emulated SPI SD card instances, e.g. two virtual drives. Each card instance raises its own rd/wr request with its LBA. The arbiter grants one request at a time, round-robin, and forwards it to the host. During the transfer it routes ack and buffer strobes only to the granted card. It sits between the host I/O bridge and the sd_card instances in the core top level.

---
 rtl/sd_pkg.sv | 16 +
 rtl/sd_host_arbiter_rr_pick.sv | 29 ++
 rtl/sd_host_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD host channel arbiter.
// Holds the arbiter state encoding and default limits.
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } state_t;

    localparam int SD_LBA_W = 32;
    localparam int TIMEOUT_CYCLES_DEF = 2**24;
    localparam int TMR_W = 25;

endpackage

// File: rtl/sd_host_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending bit after last.
// Generic enough to reuse for any shared-resource arbiter.
module rr_pick #(
    parameter int NUM_DEV = 2,
    parameter int IDX_W   = $clog2(NUM_DEV)
) (
    input  logic [NUM_DEV-1:0] pending,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the nearest hit after last wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_DEV; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_DEV);
            if (pending[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sd_host_arbiter.sv
// Round-robin arbiter sharing one host SD block channel among cards.
// Optional ISSUE-state watchdog enabled by SD_ARB_TIMEOUT_EN.
import sd_pkg::*;

module sd_host_arbiter #(
    parameter int NUM_DEV = 2,
    parameter int IDX_W   = $clog2(NUM_DEV)
`ifdef SD_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [SD_LBA_W*NUM_DEV-1:0]   dev_lba,
    input  logic [NUM_DEV-1:0]            dev_rd,
    input  logic [NUM_DEV-1:0]            dev_wr,
    output logic [NUM_DEV-1:0]            dev_ack,
    output logic [NUM_DEV-1:0]            dev_buff_wr,
    output logic [SD_LBA_W-1:0]           sd_lba,
    output logic                          sd_rd,
    output logic                          sd_wr,
    input  logic                          sd_ack,
    input  logic                          sd_buff_wr,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_idx
`ifdef SD_ARB_TIMEOUT_EN
    ,
    output logic                          timeout
`endif
);

    state_t           state;
    logic [IDX_W-1:0] last;
    logic             op_rd;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
`ifdef SD_ARB_TIMEOUT_EN
    logic [TMR_W-1:0] tmr;
`endif

    rr_pick #(
        .NUM_DEV (NUM_DEV),
        .IDX_W   (IDX_W)
    ) u_pick (
        .pending (dev_rd | dev_wr),
        .last    (last),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Grant FSM: latch a request, issue it, follow host ack, rotate.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            sd_lba    <= '0;
            grant_idx <= '0;
            last      <= IDX_W'(NUM_DEV - 1);
            busy      <= 1'b0;
            op_rd     <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            tmr       <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
`ifdef SD_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        sd_lba    <= dev_lba[SD_LBA_W*int'(pick_idx) +: SD_LBA_W];
                        op_rd     <= dev_rd[pick_idx];
                        busy      <= 1'b1;
                        state     <= ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                        tmr       <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end
`ifdef SD_ARB_TIMEOUT_EN
                    else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end
`endif
                    else begin
                        sd_rd <= op_rd;
                        sd_wr <= !op_rd;
`ifdef SD_ARB_TIMEOUT_EN
                        tmr   <= tmr + 1'b1;
`endif
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last  <= grant_idx;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route host ack and buffer strobe to the granted card only.
    always_comb begin
        dev_ack     = '0;
        dev_buff_wr = '0;
        if (state == ISSUE || state == XFER) begin
            dev_ack[grant_idx]     = sd_ack;
            dev_buff_wr[grant_idx] = sd_buff_wr;
        end
    end

endmodule
